// File: rtl/axi_lite_master_arbiter_if.sv
// AXI4-Lite channel bundle between the arbiter and one register-file slave.
// master = arbiter side, slave = register-file side.
interface axi_lite_master_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_lite_master_arbiter.sv
// Two-requester round-robin AXI4-Lite master sharing one register-file slave.
// One single-beat read or write in flight; sticky watchdog on slave stalls.
module axi_lite_master_arbiter #(
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_WDOG_CYCLES      = 1023
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic [1:0]                      req_valid,
    output logic [1:0]                      req_ready,
    input  logic [1:0]                      req_write,
    input  logic [2*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [2*C_M_AXI_DATA_WIDTH-1:0] req_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/4-1:0] req_wstrb,
    output logic [1:0]                      rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            o_wdog_trip,
    axi_lite_master_arbiter_if.master       m_axi
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam logic [15:0] WDOG_LIM = 16'(C_WDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_DATA,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            grant;
    logic            rr_last_q;
    logic            owner_q;
    logic            write_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   wstrb_q;
    logic            aw_done_q;
    logic            w_done_q;
    logic [DW-1:0]   rdata_q;
    logic [1:0]      resp_q;
    logic [15:0]     wdog_cnt_q;
    logic            wdog_trip_q;
    logic            aw_hs;
    logic            w_hs;
    logic            in_wait;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [SW-1:0]   sel_wstrb;
    logic            sel_write;

    assign aw_hs = (state_q == WR_ISSUE) && !aw_done_q && m_axi.awready;
    assign w_hs  = (state_q == WR_ISSUE) && !w_done_q && m_axi.wready;

    assign in_wait = state_q inside {WR_ISSUE, WR_RESP, RD_ISSUE, RD_DATA};

    assign sel_addr  = grant ? req_addr[2*AW-1:AW]   : req_addr[AW-1:0];
    assign sel_wdata = grant ? req_wdata[2*DW-1:DW]  : req_wdata[DW-1:0];
    assign sel_wstrb = grant ? req_wstrb[2*SW-1:SW]  : req_wstrb[SW-1:0];
    assign sel_write = grant ? req_write[1]          : req_write[0];

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        grant = 1'b0;
        unique case (req_valid)
            2'b11:   grant = ~rr_last_q;
            2'b10:   grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: write path waits for both AW and W before taking B.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = sel_write ? WR_ISSUE : RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP:  if (m_axi.bvalid)  state_d = DONE;
            RD_ISSUE: if (m_axi.arready) state_d = RD_DATA;
            RD_DATA:  if (m_axi.rvalid)  state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Latch the granted command, track AW/W progress, capture the response.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            rr_last_q <= 1'b1;
            owner_q   <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        rr_last_q <= grant;
                        owner_q   <= grant;
                        write_q   <= sel_write;
                        addr_q    <= sel_addr;
                        wdata_q   <= sel_wdata;
                        wstrb_q   <= sel_wstrb;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                WR_ISSUE: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                end
                WR_RESP: begin
                    if (m_axi.bvalid) begin
                        resp_q  <= m_axi.bresp;
                        rdata_q <= '0;
                    end
                end
                RD_DATA: begin
                    if (m_axi.rvalid) begin
                        resp_q  <= m_axi.rresp;
                        rdata_q <= m_axi.rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Watchdog: restart on every state change, count while waiting, trip sticky.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            wdog_cnt_q  <= '0;
            wdog_trip_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                wdog_cnt_q <= '0;
            end else if (in_wait && wdog_cnt_q != 16'hFFFF) begin
                wdog_cnt_q <= wdog_cnt_q + 16'd1;
            end
            if (in_wait && state_d == state_q && wdog_cnt_q >= WDOG_LIM) begin
                wdog_trip_q <= 1'b1;
            end
        end
    end

    // Moore-style outputs; req_ready is held low while reset is asserted.
    always_comb begin
        req_ready     = 2'b00;
        rsp_valid     = 2'b00;
        rsp_rdata     = '0;
        rsp_resp      = 2'b00;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (M_AXI_ARESETN && |req_valid) begin
                    req_ready = grant ? 2'b10 : 2'b01;
                end
            end
            WR_ISSUE: begin
                m_axi.awvalid = !aw_done_q;
                m_axi.wvalid  = !w_done_q;
            end
            WR_RESP:  m_axi.bready  = 1'b1;
            RD_ISSUE: m_axi.arvalid = 1'b1;
            RD_DATA:  m_axi.rready  = 1'b1;
            DONE: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                rsp_rdata = rdata_q;
                rsp_resp  = resp_q;
            end
            default: begin
            end
        endcase
    end

    assign m_axi.awaddr = write_q ? addr_q : '0;
    assign m_axi.araddr = write_q ? '0 : addr_q;
    assign m_axi.awprot = 3'b000;
    assign m_axi.arprot = 3'b000;
    assign m_axi.wdata  = wdata_q;
    assign m_axi.wstrb  = wstrb_q;
    assign o_wdog_trip  = wdog_trip_q;
endmodule
